ygr019_trns_ctl: RTL and testbench

Data-transfer sequencer for the YGR019 CD host interface. It owns the 16-bit transfer FIFO behind the host DATATRNS port (258XXX00/02) and generates the DATASTAT flags (258XXX04/06). It runs a word-counted transfer session started and stopped through the CD-side TRCTL register (0A000002). It sits between the host bus decoder and the CD-CPU register block and emits a one-cycle end-of-transfer pulse for the HIRQ logic.

---
 rtl/ygr019_trns_ctl_pkg.sv | 31 +++
 rtl/ygr019_trns_ctl_if.sv | 40 ++++
 rtl/ygr019_trns_fifo.sv | 60 ++++++
 rtl/ygr019_trns_ctl.sv | 132 +++++++++++++
 tb/tb_ygr019_trns_ctl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/ygr019_trns_ctl_pkg.sv
// Shared YGR019 definitions used by the data-transfer sequencer: TRCTL fields,
// DATASTAT layout, DATATRNS idle value and the session state encoding.
package ygr019_trns_ctl_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned XCNT_W = 16;
  localparam int unsigned TRCTL_W = 4;
  localparam logic [DATA_W-1:0] DATATRNS_INIT = 16'hFFFF;

  typedef struct packed {
    logic rsvd;
    logic flush;
    logic dir;
    logic en;
  } trctl_t;

  typedef struct packed {
    logic [12:0] rsvd;
    logic        dir;
    logic        ful;
    logic        emp;
  } datastat_t;

  typedef enum logic [1:0] {
    TRNS_IDLE   = 2'd0,
    TRNS_ACTIVE = 2'd1,
    TRNS_DRAIN  = 2'd2,
    TRNS_DONE   = 2'd3
  } trns_state_e;

endpackage

// File: rtl/ygr019_trns_ctl_if.sv
// Host/CD-side bus bundle of the transfer sequencer.
// ERR exists only when YGR019_TRNS_ERR_EN is defined.
interface ygr019_trns_ctl_if;
  import ygr019_trns_ctl_pkg::*;

  logic                TRCTL_WR;
  logic [TRCTL_W-1:0]  TRCTL;
  logic [XCNT_W-1:0]   XCNT;
  logic [DATA_W-1:0]   CDD_DI;
  logic                CDD_WR;
  logic                CDD_RD;
  logic [DATA_W-1:0]   CDD_DO;
  logic                CDD_REQ;
  logic                HOST_WR;
  logic [DATA_W-1:0]   HOST_DI;
  logic                HOST_RD;
  logic [DATA_W-1:0]   HOST_DO;
  logic [DATA_W-1:0]   DATASTAT;
  logic                XFER_END;
`ifdef YGR019_TRNS_ERR_EN
  logic                ERR;
`endif

  modport slave (
    input  TRCTL_WR, TRCTL, XCNT, CDD_DI, CDD_WR, CDD_RD, HOST_WR, HOST_DI, HOST_RD,
    output CDD_DO, CDD_REQ, HOST_DO, DATASTAT, XFER_END
`ifdef YGR019_TRNS_ERR_EN
    , output ERR
`endif
  );

  modport master (
    output TRCTL_WR, TRCTL, XCNT, CDD_DI, CDD_WR, CDD_RD, HOST_WR, HOST_DI, HOST_RD,
    input  CDD_DO, CDD_REQ, HOST_DO, DATASTAT, XFER_END
`ifdef YGR019_TRNS_ERR_EN
    , input ERR
`endif
  );

endinterface

// File: rtl/ygr019_trns_fifo.sv
// Synchronous DEPTH x 16 FIFO with flush, occupancy and flags; head is unregistered.
module ygr019_trns_fifo
  import ygr019_trns_ctl_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [DATA_W-1:0]        din_i,
  output logic [DATA_W-1:0]        head_o,
  output logic [$clog2(DEPTH):0]   occ_o,
  output logic                     emp_o,
  output logic                     ful_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [OW-1:0]     occ_q;
  logic              push_ok, pop_ok;

  assign emp_o  = (occ_q == OW'(0));
  assign ful_o  = (occ_q == OW'(DEPTH));
  assign occ_o  = occ_q;
  assign head_o = mem_q[rd_ptr_q];

  // Flush wins over any access in the same cycle.
  assign push_ok = push_i & ~ful_o & ~flush_i;
  assign pop_ok  = pop_i & ~emp_o & ~flush_i;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   occ_q <= occ_q + OW'(1);
        2'b01:   occ_q <= occ_q - OW'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: rtl/ygr019_trns_ctl.sv
// YGR019 data-transfer sequencer: word-counted TRCTL session over the DATATRNS FIFO.
// Optional sticky ERR flag when YGR019_TRNS_ERR_EN is defined.
module ygr019_trns_ctl
  import ygr019_trns_ctl_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic              CLK,
  input  logic              RST,
  ygr019_trns_ctl_if.slave  bus
);

  localparam int unsigned OW = $clog2(DEPTH) + 1;

  trns_state_e       state_q, state_d;
  logic [XCNT_W-1:0] cnt_q, cnt_d;
  logic              dir_q, dir_d;
  logic [DATA_W-1:0] host_do_q, host_do_d;
  logic              xfer_end_q, xfer_end_d;

  trctl_t            trctl_c;
  datastat_t         datastat_c;
  logic              unused_rsvd_c;
  logic [DATA_W-1:0] fifo_head;
  logic [OW-1:0]     fifo_occ;
  logic              fifo_emp, fifo_ful;
  logic              session_c, start_c, abort_c, flush_c;
  logic              push_ok_c, pop_ok_c, dec_c, drained_c;

  assign trctl_c       = trctl_t'(bus.TRCTL);
  assign unused_rsvd_c = trctl_c.rsvd;

  assign session_c = (state_q == TRNS_ACTIVE) || (state_q == TRNS_DRAIN);
  assign start_c   = bus.TRCTL_WR & trctl_c.en & (bus.XCNT != XCNT_W'(0));
  assign abort_c   = bus.TRCTL_WR & ~trctl_c.en & session_c;
  assign flush_c   = bus.TRCTL_WR & (trctl_c.flush | start_c | abort_c);

  // Acceptance uses pre-edge occupancy; the DIR-selected side owns each FIFO port.
  assign push_ok_c = ~flush_c & ~fifo_ful & (state_q == TRNS_ACTIVE) &
                     (dir_q ? bus.HOST_WR : bus.CDD_WR);
  assign pop_ok_c  = ~flush_c & ~fifo_emp & (dir_q ? bus.CDD_RD : bus.HOST_RD);
  assign dec_c     = (state_q == TRNS_ACTIVE) & (dir_q ? push_ok_c : pop_ok_c);
  assign drained_c = fifo_emp | ((fifo_occ == OW'(1)) & pop_ok_c);

  ygr019_trns_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .push_i  (push_ok_c),
    .pop_i   (pop_ok_c),
    .flush_i (flush_c),
    .din_i   (dir_q ? bus.HOST_DI : bus.CDD_DI),
    .head_o  (fifo_head),
    .occ_o   (fifo_occ),
    .emp_o   (fifo_emp),
    .ful_o   (fifo_ful)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    host_do_d = host_do_q;

    if (!dir_q && pop_ok_c)  host_do_d = fifo_head;
    else if (bus.HOST_RD)    host_do_d = DATATRNS_INIT;

    if (start_c) begin
      state_d = TRNS_ACTIVE;
      cnt_d   = bus.XCNT;
      dir_d   = trctl_c.dir;
    end else if (abort_c) begin
      state_d = TRNS_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        TRNS_ACTIVE: if (dec_c) begin
          cnt_d = cnt_q - XCNT_W'(1);
          if (cnt_q == XCNT_W'(1)) state_d = dir_q ? TRNS_DRAIN : TRNS_DONE;
        end
        TRNS_DRAIN:  if (drained_c) state_d = TRNS_DONE;
        TRNS_DONE:   state_d = TRNS_IDLE;
        default:     state_d = state_q;
      endcase
    end

    xfer_end_d = (state_d == TRNS_DONE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= TRNS_IDLE;
      cnt_q      <= '0;
      dir_q      <= 1'b0;
      host_do_q  <= DATATRNS_INIT;
      xfer_end_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      host_do_q  <= host_do_d;
      xfer_end_q <= xfer_end_d;
    end
  end

`ifdef YGR019_TRNS_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (bus.TRCTL_WR && trctl_c.en) err_d = 1'b0;
    else if (((bus.CDD_WR || bus.HOST_WR) && fifo_ful) ||
             (bus.HOST_RD && fifo_emp && (state_q == TRNS_ACTIVE))) err_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign bus.ERR = err_q;
`endif

  assign datastat_c = '{rsvd: '0, dir: dir_q, ful: fifo_ful, emp: fifo_emp};

  assign bus.DATASTAT = datastat_c;
  assign bus.HOST_DO  = host_do_q;
  assign bus.XFER_END = xfer_end_q;
  assign bus.CDD_DO   = fifo_emp ? DATATRNS_INIT : fifo_head;
  assign bus.CDD_REQ  = dir_q ? (session_c & ~fifo_emp)
                              : ((state_q == TRNS_ACTIVE) & ~fifo_ful);

endmodule

// File: tb/tb_ygr019_trns_ctl.sv
// Directed bench for ygr019_trns_ctl with hand-computed expectations.
module tb_ygr019_trns_ctl;

  localparam int unsigned DEPTH = 8;

  logic CLK = 1'b0;
  logic RST;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 CLK = ~CLK;

  ygr019_trns_ctl_if bus ();

  ygr019_trns_ctl #(.DEPTH(DEPTH)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    bus.TRCTL_WR = 1'b0; bus.TRCTL = 4'h0; bus.XCNT = 16'h0;
    bus.CDD_DI = 16'h0; bus.CDD_WR = 1'b0; bus.CDD_RD = 1'b0;
    bus.HOST_DI = 16'h0; bus.HOST_WR = 1'b0; bus.HOST_RD = 1'b0;
  endtask

  task automatic trctl_wr(input logic [3:0] v, input logic [15:0] x);
    bus.TRCTL_WR = 1'b1; bus.TRCTL = v; bus.XCNT = x;
    tick();
    bus.TRCTL_WR = 1'b0;
  endtask

  task automatic cd_push(input logic [15:0] d);
    bus.CDD_WR = 1'b1; bus.CDD_DI = d;
    tick();
    bus.CDD_WR = 1'b0;
  endtask

  task automatic cd_pop();
    bus.CDD_RD = 1'b1;
    tick();
    bus.CDD_RD = 1'b0;
  endtask

  task automatic host_wr(input logic [15:0] d);
    bus.HOST_WR = 1'b1; bus.HOST_DI = d;
    tick();
    bus.HOST_WR = 1'b0;
  endtask

  task automatic host_rd();
    bus.HOST_RD = 1'b1;
    tick();
    bus.HOST_RD = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    RST = 1'b1;
    tick(); tick();
    RST = 1'b0;
    tick();
    n_cmp++; if (bus.DATASTAT !== 16'h0001) begin n_bad++; $display("FAIL reset_datastat got %h exp 0001", bus.DATASTAT); end
    n_cmp++; if (bus.HOST_DO !== 16'hFFFF) begin n_bad++; $display("FAIL reset_host_do got %h exp ffff", bus.HOST_DO); end
    n_cmp++; if (bus.CDD_DO !== 16'hFFFF) begin n_bad++; $display("FAIL reset_cdd_do got %h exp ffff", bus.CDD_DO); end
    n_cmp++; if (bus.CDD_REQ !== 1'b0) begin n_bad++; $display("FAIL reset_cdd_req got %b exp 0", bus.CDD_REQ); end
    n_cmp++; if (bus.XFER_END !== 1'b0) begin n_bad++; $display("FAIL reset_xfer_end got %b exp 0", bus.XFER_END); end
`ifdef YGR019_TRNS_ERR_EN
    n_cmp++; if (bus.ERR !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b exp 0", bus.ERR); end
`endif
  endtask

  task automatic test_cd_to_host();
    logic [15:0] exp_words [3];
    exp_words[0] = 16'h1111; exp_words[1] = 16'h2222; exp_words[2] = 16'h3333;
    trctl_wr(4'h1, 16'd3);
    n_cmp++; if (bus.CDD_REQ !== 1'b1) begin n_bad++; $display("FAIL c2h_req_start got %b exp 1", bus.CDD_REQ); end
    for (int i = 0; i < 3; i++) cd_push(exp_words[i]);
    n_cmp++; if (bus.DATASTAT !== 16'h0000) begin n_bad++; $display("FAIL c2h_datastat got %h exp 0000", bus.DATASTAT); end
    n_cmp++; if (bus.CDD_DO !== 16'h1111) begin n_bad++; $display("FAIL c2h_head got %h exp 1111", bus.CDD_DO); end
    for (int i = 0; i < 3; i++) begin
      host_rd();
      n_cmp++; if (bus.HOST_DO !== exp_words[i]) begin n_bad++; $display("FAIL c2h_rd%0d got %h exp %h", i, bus.HOST_DO, exp_words[i]); end
      n_cmp++; if (bus.XFER_END !== (i == 2)) begin n_bad++; $display("FAIL c2h_xfer_end%0d got %b exp %b", i, bus.XFER_END, (i == 2)); end
    end
    tick();
    n_cmp++; if (bus.XFER_END !== 1'b0) begin n_bad++; $display("FAIL c2h_xfer_end_pulse got %b exp 0", bus.XFER_END); end
    n_cmp++; if (bus.CDD_REQ !== 1'b0) begin n_bad++; $display("FAIL c2h_req_after got %b exp 0", bus.CDD_REQ); end
    n_cmp++; if (bus.HOST_DO !== 16'h3333) begin n_bad++; $display("FAIL c2h_hold got %h exp 3333", bus.HOST_DO); end
  endtask

  task automatic test_host_to_cd();
    trctl_wr(4'h3, 16'(DEPTH + 2));
    n_cmp++; if (bus.DATASTAT !== 16'h0005) begin n_bad++; $display("FAIL h2c_start_stat got %h exp 0005", bus.DATASTAT); end
    n_cmp++; if (bus.CDD_REQ !== 1'b0) begin n_bad++; $display("FAIL h2c_req_empty got %b exp 0", bus.CDD_REQ); end
    for (int i = 0; i < DEPTH; i++) host_wr(16'hA000 + 16'(i));
    n_cmp++; if (bus.DATASTAT !== 16'h0006) begin n_bad++; $display("FAIL h2c_full_stat got %h exp 0006", bus.DATASTAT); end
    n_cmp++; if (bus.CDD_REQ !== 1'b1) begin n_bad++; $display("FAIL h2c_req_full got %b exp 1", bus.CDD_REQ); end
    host_wr(16'hBEEF);
    n_cmp++; if (bus.DATASTAT !== 16'h0006) begin n_bad++; $display("FAIL h2c_drop_stat got %h exp 0006", bus.DATASTAT); end
`ifdef YGR019_TRNS_ERR_EN
    n_cmp++; if (bus.ERR !== 1'b1) begin n_bad++; $display("FAIL h2c_err_full got %b exp 1", bus.ERR); end
`endif
    cd_pop(); cd_pop();
    n_cmp++; if (bus.CDD_DO !== 16'hA002) begin n_bad++; $display("FAIL h2c_head_after2 got %h exp a002", bus.CDD_DO); end
    n_cmp++; if (bus.DATASTAT !== 16'h0004) begin n_bad++; $display("FAIL h2c_stat_after2 got %h exp 0004", bus.DATASTAT); end
    host_wr(16'hA008); host_wr(16'hA009);
    n_cmp++; if (bus.DATASTAT !== 16'h0006) begin n_bad++; $display("FAIL h2c_refill_stat got %h exp 0006", bus.DATASTAT); end
    cd_pop();
    host_wr(16'hDEAD);
    n_cmp++; if (bus.DATASTAT !== 16'h0004) begin n_bad++; $display("FAIL h2c_drain_rejects got %h exp 0004", bus.DATASTAT); end
    n_cmp++; if (bus.CDD_DO !== 16'hA003) begin n_bad++; $display("FAIL h2c_drain_head got %h exp a003", bus.CDD_DO); end
    for (int i = 0; i < 6; i++) begin
      cd_pop();
      n_cmp++; if (bus.CDD_DO !== 16'hA004 + 16'(i)) begin n_bad++; $display("FAIL h2c_pop%0d got %h exp %h", i, bus.CDD_DO, 16'hA004 + 16'(i)); end
      n_cmp++; if (bus.XFER_END !== 1'b0) begin n_bad++; $display("FAIL h2c_early_end%0d got %b exp 0", i, bus.XFER_END); end
    end
    cd_pop();
    n_cmp++; if (bus.XFER_END !== 1'b1) begin n_bad++; $display("FAIL h2c_xfer_end got %b exp 1", bus.XFER_END); end
    n_cmp++; if (bus.DATASTAT !== 16'h0005) begin n_bad++; $display("FAIL h2c_end_stat got %h exp 0005", bus.DATASTAT); end
    tick();
    n_cmp++; if (bus.XFER_END !== 1'b0) begin n_bad++; $display("FAIL h2c_xfer_end_pulse got %b exp 0", bus.XFER_END); end
    n_cmp++; if (bus.CDD_REQ !== 1'b0) begin n_bad++; $display("FAIL h2c_req_after got %b exp 0", bus.CDD_REQ); end
  endtask

  task automatic test_empty_read();
    trctl_wr(4'h1, 16'd2);
`ifdef YGR019_TRNS_ERR_EN
    n_cmp++; if (bus.ERR !== 1'b0) begin n_bad++; $display("FAIL er_err_clear got %b exp 0", bus.ERR); end
`endif
    host_rd();
    n_cmp++; if (bus.HOST_DO !== 16'hFFFF) begin n_bad++; $display("FAIL er_host_do got %h exp ffff", bus.HOST_DO); end
`ifdef YGR019_TRNS_ERR_EN
    n_cmp++; if (bus.ERR !== 1'b1) begin n_bad++; $display("FAIL er_err_set got %b exp 1", bus.ERR); end
`endif
    cd_push(16'h5A01); cd_push(16'h5A02);
    host_rd();
    n_cmp++; if (bus.XFER_END !== 1'b0) begin n_bad++; $display("FAIL er_cnt_kept got %b exp 0", bus.XFER_END); end
    host_rd();
    n_cmp++; if (bus.HOST_DO !== 16'h5A02) begin n_bad++; $display("FAIL er_last_word got %h exp 5a02", bus.HOST_DO); end
    n_cmp++; if (bus.XFER_END !== 1'b1) begin n_bad++; $display("FAIL er_xfer_end got %b exp 1", bus.XFER_END); end
    tick();
  endtask

  task automatic test_abort();
    trctl_wr(4'h1, 16'd10);
    for (int i = 0; i < 4; i++) cd_push(16'hC000 + 16'(i));
    n_cmp++; if (bus.DATASTAT !== 16'h0000) begin n_bad++; $display("FAIL ab_queued got %h exp 0000", bus.DATASTAT); end
    trctl_wr(4'h0, 16'd0);
    n_cmp++; if (bus.DATASTAT !== 16'h0001) begin n_bad++; $display("FAIL ab_emp got %h exp 0001", bus.DATASTAT); end
    n_cmp++; if (bus.CDD_REQ !== 1'b0) begin n_bad++; $display("FAIL ab_idle_req got %b exp 0", bus.CDD_REQ); end
    n_cmp++; if (bus.XFER_END !== 1'b0) begin n_bad++; $display("FAIL ab_no_end0 got %b exp 0", bus.XFER_END); end
    tick();
    n_cmp++; if (bus.XFER_END !== 1'b0) begin n_bad++; $display("FAIL ab_no_end1 got %b exp 0", bus.XFER_END); end
    cd_push(16'h7777);
    n_cmp++; if (bus.DATASTAT !== 16'h0001) begin n_bad++; $display("FAIL ab_idle_push got %h exp 0001", bus.DATASTAT); end
  endtask

  task automatic test_back_to_back();
    trctl_wr(4'h1, 16'd10);
    for (int i = 1; i <= 3; i++) cd_push(16'h0C00 + 16'(i));
    bus.CDD_WR = 1'b1; bus.CDD_DI = 16'h0C04; bus.HOST_RD = 1'b1;
    tick();
    bus.CDD_WR = 1'b0; bus.HOST_RD = 1'b0;
    n_cmp++; if (bus.HOST_DO !== 16'h0C01) begin n_bad++; $display("FAIL bb_simul_rd got %h exp 0c01", bus.HOST_DO); end
    n_cmp++; if (bus.CDD_DO !== 16'h0C02) begin n_bad++; $display("FAIL bb_simul_head got %h exp 0c02", bus.CDD_DO); end
    for (int i = 2; i <= 4; i++) begin
      n_cmp++; if (bus.DATASTAT !== 16'h0000) begin n_bad++; $display("FAIL bb_occ%0d got %h exp 0000", i, bus.DATASTAT); end
      host_rd();
      n_cmp++; if (bus.HOST_DO !== 16'h0C00 + 16'(i)) begin n_bad++; $display("FAIL bb_rd%0d got %h exp %h", i, bus.HOST_DO, 16'h0C00 + 16'(i)); end
    end
    n_cmp++; if (bus.DATASTAT !== 16'h0001) begin n_bad++; $display("FAIL bb_drained got %h exp 0001", bus.DATASTAT); end
    cd_push(16'h0D01); cd_push(16'h0D02);
    bus.TRCTL_WR = 1'b1; bus.TRCTL = 4'h5; bus.XCNT = 16'd0;
    bus.CDD_WR = 1'b1; bus.CDD_DI = 16'h0D03;
    tick();
    bus.TRCTL_WR = 1'b0; bus.CDD_WR = 1'b0;
    n_cmp++; if (bus.DATASTAT !== 16'h0001) begin n_bad++; $display("FAIL bb_flush_push got %h exp 0001", bus.DATASTAT); end
    n_cmp++; if (bus.CDD_DO !== 16'hFFFF) begin n_bad++; $display("FAIL bb_flush_head got %h exp ffff", bus.CDD_DO); end
    n_cmp++; if (bus.CDD_REQ !== 1'b1) begin n_bad++; $display("FAIL bb_flush_active got %b exp 1", bus.CDD_REQ); end
  endtask

  task automatic test_reset_drain();
    trctl_wr(4'h3, 16'd2);
    host_wr(16'hE001); host_wr(16'hE002);
    n_cmp++; if (bus.CDD_REQ !== 1'b1) begin n_bad++; $display("FAIL rd_drain_req got %b exp 1", bus.CDD_REQ); end
    n_cmp++; if (bus.DATASTAT !== 16'h0004) begin n_bad++; $display("FAIL rd_drain_stat got %h exp 0004", bus.DATASTAT); end
    #2;
    RST = 1'b1;
    #1;
    n_cmp++; if (bus.DATASTAT !== 16'h0001) begin n_bad++; $display("FAIL rd_rst_stat got %h exp 0001", bus.DATASTAT); end
    n_cmp++; if (bus.CDD_REQ !== 1'b0) begin n_bad++; $display("FAIL rd_rst_req got %b exp 0", bus.CDD_REQ); end
    n_cmp++; if (bus.CDD_DO !== 16'hFFFF) begin n_bad++; $display("FAIL rd_rst_cdd_do got %h exp ffff", bus.CDD_DO); end
    n_cmp++; if (bus.HOST_DO !== 16'hFFFF) begin n_bad++; $display("FAIL rd_rst_host_do got %h exp ffff", bus.HOST_DO); end
    tick();
    RST = 1'b0;
    tick();
    n_cmp++; if (bus.XFER_END !== 1'b0) begin n_bad++; $display("FAIL rd_rst_no_end got %b exp 0", bus.XFER_END); end
    n_cmp++; if (bus.CDD_REQ !== 1'b0) begin n_bad++; $display("FAIL rd_rst_idle got %b exp 0", bus.CDD_REQ); end
  endtask

  initial begin
    test_reset();
    test_cd_to_host();
    test_host_to_cd();
    test_empty_read();
    test_abort();
    test_back_to_back();
    test_reset_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
